i2s_tx_master: RTL and testbench
================================

I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width per channel, range 16..SLOT_W.
REQ-002 SHALL have parameter SLOT_W, default 32, BCLK periods per channel slot.
REQ-003 SHALL have parameter BCLK_DIV, default 10, clk cycles per BCLK half-period, minimum 2.
REQ-004 SHALL have parameter MODE, default 0; 0 = I2S (one-BCLK data delay), 1 = left-justified.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input, single system clock (50 MHz); reset input, asynchronous, active-low.
REQ-006 Port `clk`  input  1  system clock; all logic in this single domain.
REQ-007 Port `reset`  input  1  asynchronous active-low reset.
REQ-008 Port `in_valid`  input  1  stereo sample pair present.
REQ-009 Port `in_ready`  output  1  holding register empty; pair accepted when in_valid and in_ready are both high on a clk edge.
REQ-010 Port `in_left`  input  DATA_W  left sample, two's complement.
REQ-011 Port `in_right`  input  DATA_W  right sample, two's complement.
REQ-012 Port `bclk`  output  1  generated bit clock, period 2*BCLK_DIV clk cycles.
REQ-013 Port `daclrc`  output  1  word select: 0 = left slot, 1 = right slot.
REQ-014 Port `dacdat`  output  1  serial data, MSB first.
REQ-015 Port `underrun`  output  1  one-clk pulse when a frame starts with no sample available.

Function
REQ-016 SHALL keep a divider counter 0..BCLK_DIV-1 that increments every clk, wraps to 0, and toggles bclk on the cycle it equals BCLK_DIV-1.
REQ-017 SHALL define a "fall event" as the clk cycle on which bclk is toggled 1->0; daclrc, dacdat, the bit counter and frame loading SHALL update only on fall events.
REQ-018 SHALL keep a bit counter p, range 0..2*SLOT_W-1, advanced on each fall event and wrapping 2*SLOT_W-1 -> 0; p = 0 is frame start.
REQ-019 SHALL drive daclrc = 0 for p in 0..SLOT_W-1 and 1 for p in SLOT_W..2*SLOT_W-1, in both modes.
REQ-020 SHALL form the frame vector F (2*SLOT_W bits, MSB first) as {left, (SLOT_W-DATA_W) zeros, right, (SLOT_W-DATA_W) zeros}.
REQ-021 MODE=1: at position p, dacdat SHALL equal F bit p counted from the MSB.
REQ-022 MODE=0: at p > 0, dacdat SHALL equal F bit p-1; at p = 0, dacdat SHALL equal the last bit of the previous frame's F, which is 0 after reset.
REQ-023 SHALL hold one stereo pair in a holding register; in_ready SHALL be registered and equal to NOT(holding full).
REQ-024 On the frame-start fall event, if holding is full, SHALL move it into the frame shift register and mark holding empty; in_ready rises on the next clk.
REQ-025 On the frame-start fall event, if holding is empty, SHALL load F = all zeros (mute frame) and pulse underrun high for exactly that one clk.
REQ-026 Acceptance on the same clk as a frame-start fall event with holding empty SHALL fill holding for the next frame; that pair SHALL NOT enter the current frame.
REQ-027 SHALL ignore in_left and in_right when in_valid is low or in_ready is low.
REQ-028 Samples SHALL be transmitted unmodified; no saturation, truncation or sign extension.

Reset
REQ-029 While reset = 0, outputs SHALL be: bclk=0, daclrc=0, dacdat=0, underrun=0, in_ready=1.
REQ-030 During reset, the divider SHALL be 0, p SHALL be 2*SLOT_W-1, holding SHALL be empty, shift register and previous-frame bit SHALL be 0.
REQ-031 The first fall event after reset release SHALL occur at clk cycle 2*BCLK_DIV and SHALL be a frame start (p = 0).
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately (asynchronous) and discard any held pair.

Verification
Benches use DATA_W=24, SLOT_W=32, BCLK_DIV=4.
REQ-033 Reset/timing: release reset with in_valid=0 -> bclk rises at clk cycle 4 and falls at cycle 8, period 8 clk; underrun pulses at cycle 8; daclrc toggles every 256 clk.
REQ-034 MODE=1: write pair L=24'hA5A5A5, R=24'h3C3C3C before the first frame start -> left slot = 101001011010010110100101 followed by 8 zeros; right slot = 001111000011110000111100 followed by 8 zeros; daclrc and the MSB change on the same fall event.
REQ-035 MODE=0: same pair -> dacdat at p=0 is 0; L MSB appears at p=1; R MSB appears at p=33, one BCLK after daclrc rises.
REQ-036 Backpressure: hold in_valid=1 with three distinct pairs -> first pair accepted at once; second pair accepted the clk after the first frame start; in_ready stays low until each frame start; pairs appear in order with no loss and no duplication.
REQ-037 Underrun: supply one pair, then none -> one frame carries the data, the next frame is all zeros with one underrun pulse per frame start.
REQ-038 Mid-frame reset: assert reset at p=40 with a pair held -> all outputs return to zero at once; after release the first frame is a mute frame with underrun pulsed.

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S / left-justified stereo transmitter with a one-pair holding register.
// The system clock is divided down to bclk; all serial outputs change on bclk falling edges.
module i2s_tx_master #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 10,
    parameter int MODE     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    output logic              bclk,
    output logic              daclrc,
    output logic              dacdat,
    output logic              underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int PAD_W   = SLOT_W - DATA_W;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int P_W     = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [P_W-1:0]   P_LAST    = P_W'(FRAME_W - 1);
    localparam logic [P_W-1:0]   P_R_START = P_W'(SLOT_W);

    logic [DIV_W-1:0]   div;
    logic [P_W-1:0]     p;
    logic [P_W-1:0]     p_next;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] load_word;
    logic [SLOT_W-1:0]  left_slot;
    logic [SLOT_W-1:0]  right_slot;
    logic [DATA_W-1:0]  hold_l;
    logic [DATA_W-1:0]  hold_r;
    logic               hold_full;
    logic               div_wrap;
    logic               fall;
    logic               frame_start;
    logic               accept;

    // Samples sit left-aligned in their slot with zero padding below.
    assign left_slot  = SLOT_W'(hold_l) << PAD_W;
    assign right_slot = SLOT_W'(hold_r) << PAD_W;

    assign div_wrap    = (div == DIV_LAST);
    assign fall        = div_wrap && bclk;
    assign p_next      = (p == P_LAST) ? '0 : p + P_W'(1);
    assign frame_start = fall && (p_next == '0);
    assign load_word   = hold_full ? {left_slot, right_slot} : '0;
    assign in_ready    = !hold_full;
    assign accept      = in_valid && in_ready;

    // NOTE: every register below is assigned with <= so all of them see the
    // pre-edge values of fall/frame_start; blocking here would reorder updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            bclk      <= 1'b0;
            p         <= P_LAST;
            daclrc    <= 1'b0;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
            shift_reg <= '0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            div      <= div_wrap ? '0 : div + DIV_W'(1);
            underrun <= 1'b0;
            if (div_wrap) begin
                bclk <= ~bclk;
            end

            if (fall) begin
                p      <= p_next;
                daclrc <= (p_next >= P_R_START);
                if (frame_start) begin
                    underrun <= !hold_full;
                    // I2S delays data one bclk: the previous frame's last bit
                    // still sits at the top of the shift register.
                    if (MODE == 1) begin
                        dacdat    <= load_word[FRAME_W-1];
                        shift_reg <= load_word << 1;
                    end else begin
                        dacdat    <= shift_reg[FRAME_W-1];
                        shift_reg <= load_word;
                    end
                end else begin
                    dacdat    <= shift_reg[FRAME_W-1];
                    shift_reg <= shift_reg << 1;
                end
            end

            if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= in_left;
                hold_r    <= in_right;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: an I2S and a left-justified instance share one stimulus
// stream and are compared every clk against a frame-level model built from clk counts.
module tb_i2s_tx_master;

    localparam int DATA_W   = 24;
    localparam int SLOT_W   = 32;
    localparam int BCLK_DIV = 4;
    localparam int FW       = 2 * SLOT_W;
    localparam int BP       = 2 * BCLK_DIV;
    localparam int FRAME_CLK = FW * BP;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_left = '0;
    logic [DATA_W-1:0] in_right = '0;
    logic in_ready0, bclk0, daclrc0, dacdat0, underrun0;
    logic in_ready1, bclk1, daclrc1, dacdat1, underrun1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k counts clk edges since reset release.
    int                k;
    bit                m_full, m_acc, m_under;
    logic [DATA_W-1:0] m_l, m_r;
    logic [FW-1:0]     frames[$];

    always #5 clk = ~clk;

    i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(0)) u_i2s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_left(in_left), .in_right(in_right), .bclk(bclk0), .daclrc(daclrc0),
        .dacdat(dacdat0), .underrun(underrun0)
    );

    i2s_tx_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV), .MODE(1)) u_lj (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_left(in_left), .in_right(in_right), .bclk(bclk1), .daclrc(daclrc1),
        .dacdat(dacdat1), .underrun(underrun1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        return {l, {(SLOT_W-DATA_W){1'b0}}, r, {(SLOT_W-DATA_W){1'b0}}};
    endfunction

    task automatic model_clear();
        k = 0;
        m_full = 1'b0;
        m_acc = 1'b0;
        m_under = 1'b0;
        m_l = '0;
        m_r = '0;
        frames.delete();
    endtask

    // One clk edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit fs;
        int f;
        k++;
        f = k / BP;
        fs = (k % BP == 0) && ((f - 1) % FW == 0);
        m_acc = in_valid && !m_full;
        m_under = fs && !m_full;
        if (fs) frames.push_back(m_full ? make_frame(m_l, m_r) : '0);
        if (m_acc) begin
            m_full = 1'b1;
            m_l = in_left;
            m_r = in_right;
        end else if (fs) begin
            m_full = 1'b0;
        end
    endtask

    function automatic logic exp_bclk();
        return ((k / BCLK_DIV) % 2) == 1;
    endfunction

    function automatic logic exp_daclrc();
        int f = k / BP;
        if (f == 0) return 1'b0;
        return ((f - 1) % FW) >= SLOT_W;
    endfunction

    function automatic logic exp_dacdat(input int mode);
        int f = k / BP;
        int p, fr;
        logic [FW-1:0] w;
        if (f == 0) return 1'b0;
        p  = (f - 1) % FW;
        fr = (f - 1) / FW;
        if (mode == 1) begin
            w = frames[fr];
            return w[FW-1-p];
        end
        if (p > 0) begin
            w = frames[fr];
            return w[FW-p];
        end
        if (fr == 0) return 1'b0;
        w = frames[fr-1];
        return w[0];
    endfunction

    task automatic compare_all();
        if (!reset) begin
            check_bit("rst.in_ready0", in_ready0, 1'b1);
            check_bit("rst.in_ready1", in_ready1, 1'b1);
            check("rst.i2s_outs", 64'({bclk0, daclrc0, dacdat0, underrun0}), 64'd0);
            check("rst.lj_outs", 64'({bclk1, daclrc1, dacdat1, underrun1}), 64'd0);
        end else begin
            check_bit("i2s.in_ready", in_ready0, !m_full);
            check_bit("lj.in_ready", in_ready1, !m_full);
            check_bit("i2s.bclk", bclk0, exp_bclk());
            check_bit("lj.bclk", bclk1, exp_bclk());
            check_bit("i2s.daclrc", daclrc0, exp_daclrc());
            check_bit("lj.daclrc", daclrc1, exp_daclrc());
            check_bit("i2s.dacdat", dacdat0, exp_dacdat(0));
            check_bit("lj.dacdat", dacdat1, exp_dacdat(1));
            check_bit("i2s.underrun", underrun0, m_under);
            check_bit("lj.underrun", underrun1, m_under);
        end
    endtask

    // Advance one clk and compare on the falling edge; callers change inputs afterwards.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        in_valid = 1'b0;
        model_clear();
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    logic [DATA_W-1:0] pl[3] = '{24'h123456, 24'h800001, 24'h7FFFFE};
    logic [DATA_W-1:0] pr[3] = '{24'hABCDEF, 24'h00FF00, 24'hFFFFFF};

    initial begin
        logic [FW-1:0] cap0, cap1;
        int acc_k[$];
        int idx, rate;

        model_clear();
        #3;

        // Idle timing: bclk, daclrc and underrun cadence with no samples.
        apply_reset(3);
        repeat (FRAME_CLK + 80) begin
            cycle();
            if (k == 3)   check_bit("t.bclk_low_at_3", bclk0, 1'b0);
            if (k == 4)   check_bit("t.bclk_rise_at_4", bclk0, 1'b1);
            if (k == 8)   check("t.edge8_bclk_underrun", 64'({bclk0, underrun0}), 64'b01);
            if (k == 9)   check_bit("t.underrun_one_clk", underrun0, 1'b0);
            if (k == 263) check_bit("t.daclrc_left_263", daclrc1, 1'b0);
            if (k == 264) check_bit("t.daclrc_right_264", daclrc1, 1'b1);
            if (k == 520) check("t.frame2_start", 64'({daclrc1, underrun1}), 64'b01);
        end

        // Known pair before the first frame: capture both serial streams.
        apply_reset(2);
        in_valid = 1'b1;
        in_left  = 24'hA5A5A5;
        in_right = 24'h3C3C3C;
        cap0 = '0;
        cap1 = '0;
        repeat (FRAME_CLK + 80) begin
            cycle();
            in_valid = 1'b0;
            if (k % BP == 0 && k / BP >= 1 && k / BP <= FW) begin
                cap0[FW - k / BP] = dacdat0;
                cap1[FW - k / BP] = dacdat1;
            end
        end
        check("lj.frame0_bits", cap1, {24'hA5A5A5, 8'h00, 24'h3C3C3C, 8'h00});
        check("i2s.frame0_bits", cap0, {1'b0, 24'hA5A5A5, 8'h00, 24'h3C3C3C, 7'h00});

        // Backpressure: in_valid held high across three pairs.
        apply_reset(2);
        idx = 0;
        in_valid = 1'b1;
        in_left  = pl[0];
        in_right = pr[0];
        repeat (4 * FRAME_CLK + 40) begin
            cycle();
            if (m_acc) begin
                acc_k.push_back(k);
                idx++;
            end
            in_valid = (idx < 3);
            if (idx < 3) begin
                in_left  = pl[idx];
                in_right = pr[idx];
            end
        end
        check("bp.accept_count", 64'(acc_k.size()), 64'd3);
        check("bp.accept_edge0", 64'(acc_k[0]), 64'd1);
        check("bp.accept_edge1", 64'(acc_k[1]), 64'd9);
        check("bp.accept_edge2", 64'(acc_k[2]), 64'd521);
        check("bp.frame0", frames[0], make_frame(pl[0], pr[0]));
        check("bp.frame1", frames[1], make_frame(pl[1], pr[1]));
        check("bp.frame2", frames[2], make_frame(pl[2], pr[2]));
        check("bp.frame3_mute", frames[3], '0);

        // Random offered load, varying between starved and saturated.
        apply_reset(2);
        for (int seg = 0; seg < 8; seg++) begin
            case ($urandom_range(0, 2))
                0:       rate = 1;
                1:       rate = 4;
                default: rate = 200;
            endcase
            repeat (FRAME_CLK) begin
                cycle();
                in_valid = ($urandom_range(0, 999) < rate);
                in_left  = DATA_W'($urandom);
                in_right = DATA_W'($urandom);
            end
        end

        // Mid-frame reset at p=40 with a pair held.
        apply_reset(2);
        in_valid = 1'b1;
        in_left  = 24'h111111;
        in_right = 24'h222222;
        while (k < BP * (40 + 1)) begin
            cycle();
            if (m_acc && k > 1) in_valid = 1'b0;
            if (k == 8) begin
                in_left  = 24'h333333;
                in_right = 24'h444444;
            end
        end
        check_bit("mr.holding_full_before", in_ready1, 1'b0);
        reset = 1'b0;
        #1;
        check("mr.async_outs", 64'({bclk0, daclrc0, dacdat0, underrun0, bclk1, daclrc1, dacdat1, underrun1}), 64'd0);
        check("mr.async_ready", 64'({in_ready0, in_ready1}), 64'b11);
        apply_reset(3);
        repeat (FRAME_CLK + 20) begin
            cycle();
            if (k == 8) check("mr.mute_underrun", 64'({underrun0, underrun1}), 64'b11);
        end
        check("mr.first_frame_mute", frames[0], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
